// File: rtl/dac_cic_interpolator_if.sv
// Sample stream bundle between the baseband source and the CIC interpolator:
// input handshake plus the real-time DAC-side outputs.
interface dac_cic_interpolator_if #(
    parameter int WIDTH = 16
);
    logic signed [WIDTH-1:0] i_inph;
    logic signed [WIDTH-1:0] i_quad;
    logic                    i_valid;
    logic                    o_ready;
    logic signed [WIDTH-1:0] o_inph;
    logic signed [WIDTH-1:0] o_quad;
    logic                    o_valid;
    logic                    o_underflow;
    logic                    o_sat;
    logic                    o_running;

    modport master (
        output i_inph, i_quad, i_valid,
        input  o_ready, o_inph, o_quad, o_valid, o_underflow, o_sat, o_running
    );

    modport slave (
        input  i_inph, i_quad, i_valid,
        output o_ready, o_inph, o_quad, o_valid, o_underflow, o_sat, o_running
    );
endinterface

// File: rtl/dac_cic_interpolator.sv
// I/Q CIC interpolator: one baseband sample per RATE clocks in, one filtered sample per clock out.
// Missed input slots are zero-stuffed and flagged; MISS_LIMIT misses in a row drop back to IDLE.
module dac_cic_interpolator #(
    parameter int WIDTH      = 16,
    parameter int RATE       = 8,
    parameter int STAGES     = 3,
    parameter int MISS_LIMIT = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_sw_rst_strb,
    dac_cic_interpolator_if.slave bus
);
    localparam int LOG2R  = $clog2(RATE);
    localparam int ACC_W  = WIDTH + STAGES * LOG2R;
    localparam int SHIFT  = (STAGES - 1) * LOG2R;
    localparam int CNT_W  = LOG2R;
    localparam int MISS_W = $clog2(MISS_LIMIT + 1);
    localparam int LAT    = STAGES + 2;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [MISS_W-1:0]       miss_q;
    logic                    ready_q;
    logic                    running_q;
    logic                    underflow_q;

    logic signed [ACC_W-1:0] cdly_q   [2][STAGES];
    logic signed [ACC_W-1:0] comb_q   [2];
    logic signed [ACC_W-1:0] up_q     [2];
    logic signed [ACC_W-1:0] integ_q  [2][STAGES];
    logic signed [WIDTH-1:0] out_q    [2];
    logic                    sat_q;
    logic                    slot_q;
    logic [LAT:0]            vld_q;

    logic                    slot_s;
    logic                    accept_s;
    logic                    miss_s;
    logic                    limit_s;
    logic                    clear_s;
    logic                    load_s;
    logic signed [ACC_W-1:0] x_s        [2];
    logic signed [ACC_W-1:0] tap_s      [2][STAGES];
    logic signed [ACC_W-1:0] comb_out_s [2];
    logic [WIDTH:0]          sres_s     [2];

    // Arithmetic shift by the CIC gain, then clamp; MSB of the result flags a clamp.
    function automatic logic [WIDTH:0] shift_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] sh;
        sh = acc >>> SHIFT;
        if (sh > SAT_MAX) begin
            return {1'b1, SAT_MAX[WIDTH-1:0]};
        end else if (sh < SAT_MIN) begin
            return {1'b1, SAT_MIN[WIDTH-1:0]};
        end else begin
            return {1'b0, sh[WIDTH-1:0]};
        end
    endfunction

    assign slot_s   = (state_q == ST_RUN) && (cnt_q == CNT_W'(RATE - 1));
    assign accept_s = bus.i_valid && ready_q && !i_sw_rst_strb;
    assign miss_s   = slot_s && !bus.i_valid && !i_sw_rst_strb;
    assign limit_s  = miss_s && (miss_q == MISS_W'(MISS_LIMIT - 1));
    assign clear_s  = i_sw_rst_strb || limit_s;
    assign load_s   = accept_s || miss_s;

    assign x_s[0] = {{(ACC_W-WIDTH){bus.i_inph[WIDTH-1]}}, bus.i_inph};
    assign x_s[1] = {{(ACC_W-WIDTH){bus.i_quad[WIDTH-1]}}, bus.i_quad};

    // Comb cascade at the input slot; a missed slot pushes zero through the combs.
    always_comb begin
        logic signed [ACC_W-1:0] acc_v;
        acc_v = {ACC_W{1'b0}};
        for (int c = 0; c < 2; c++) begin
            acc_v = accept_s ? x_s[c] : {ACC_W{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                tap_s[c][k] = acc_v;
                acc_v       = acc_v - cdly_q[c][k];
            end
            comb_out_s[c] = acc_v;
        end
    end

    // Output scaling for both channels.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            sres_s[c] = shift_sat(integ_q[c][STAGES-1]);
        end
    end

    // Control FSM: slot phase counter, miss tracking, handshake and status flags.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            miss_q      <= {MISS_W{1'b0}};
            ready_q     <= 1'b0;
            running_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else if (i_sw_rst_strb) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            miss_q      <= {MISS_W{1'b0}};
            ready_q     <= 1'b0;
            running_q   <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    underflow_q <= 1'b0;
                    if (accept_s) begin
                        state_q   <= ST_RUN;
                        cnt_q     <= {CNT_W{1'b0}};
                        miss_q    <= {MISS_W{1'b0}};
                        ready_q   <= 1'b0;
                        running_q <= 1'b1;
                    end else begin
                        ready_q   <= 1'b1;
                        running_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    cnt_q       <= cnt_q + CNT_W'(1);
                    ready_q     <= (cnt_q == CNT_W'(RATE - 2));
                    underflow_q <= miss_s;
                    if (slot_s && bus.i_valid) begin
                        miss_q <= {MISS_W{1'b0}};
                    end else if (limit_s) begin
                        state_q   <= ST_IDLE;
                        cnt_q     <= {CNT_W{1'b0}};
                        miss_q    <= {MISS_W{1'b0}};
                        ready_q   <= 1'b1;
                        running_q <= 1'b0;
                    end else if (miss_s) begin
                        miss_q <= miss_q + MISS_W'(1);
                    end else begin
                        miss_q <= miss_q;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= {CNT_W{1'b0}};
                    miss_q      <= {MISS_W{1'b0}};
                    ready_q     <= 1'b0;
                    running_q   <= 1'b0;
                    underflow_q <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: comb register, zero-stuffing upsampler, integrators, output stage, valid delay.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < STAGES; k++) begin
                    cdly_q[c][k]  <= {ACC_W{1'b0}};
                    integ_q[c][k] <= {ACC_W{1'b0}};
                end
                comb_q[c] <= {ACC_W{1'b0}};
                up_q[c]   <= {ACC_W{1'b0}};
                out_q[c]  <= {WIDTH{1'b0}};
            end
            sat_q  <= 1'b0;
            slot_q <= 1'b0;
            vld_q  <= {(LAT+1){1'b0}};
        end else if (clear_s) begin
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < STAGES; k++) begin
                    cdly_q[c][k]  <= {ACC_W{1'b0}};
                    integ_q[c][k] <= {ACC_W{1'b0}};
                end
                comb_q[c] <= {ACC_W{1'b0}};
                up_q[c]   <= {ACC_W{1'b0}};
                out_q[c]  <= {WIDTH{1'b0}};
            end
            sat_q  <= 1'b0;
            slot_q <= 1'b0;
            vld_q  <= {(LAT+1){1'b0}};
        end else begin
            if (load_s) begin
                for (int c = 0; c < 2; c++) begin
                    for (int k = 0; k < STAGES; k++) begin
                        cdly_q[c][k] <= tap_s[c][k];
                    end
                    comb_q[c] <= comb_out_s[c];
                end
            end else begin
                comb_q <= comb_q;
            end
            slot_q <= load_s;
            if (state_q == ST_RUN) begin
                for (int c = 0; c < 2; c++) begin
                    up_q[c]       <= slot_q ? comb_q[c] : {ACC_W{1'b0}};
                    integ_q[c][0] <= integ_q[c][0] + up_q[c];
                    for (int k = 1; k < STAGES; k++) begin
                        integ_q[c][k] <= integ_q[c][k] + integ_q[c][k-1];
                    end
                    out_q[c] <= sres_s[c][WIDTH-1:0];
                end
                sat_q <= sres_s[0][WIDTH] | sres_s[1][WIDTH];
            end else begin
                sat_q <= 1'b0;
            end
            if ((state_q == ST_RUN) || accept_s) begin
                vld_q <= {vld_q[LAT-1:0], 1'b1};
            end else begin
                vld_q <= {(LAT+1){1'b0}};
            end
        end
    end

    assign bus.o_ready     = ready_q && !i_sw_rst_strb;
    assign bus.o_inph      = out_q[0];
    assign bus.o_quad      = out_q[1];
    assign bus.o_valid     = vld_q[LAT];
    assign bus.o_underflow = underflow_q;
    assign bus.o_sat       = sat_q;
    assign bus.o_running   = running_q;
endmodule
